vrp_disp_idx: RTL and testbench



---
 rtl/vrp_disp_pkg.sv | 16 +
 rtl/vrp_disp_fifo.sv | 57 +++++
 rtl/vrp_disp_idx.sv | 76 +++++++
 tb/tb_vrp_disp_idx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/vrp_disp_pkg.sv
// Shared sizing for the VRP dispatcher: default channel FIFO depth and the
// pointer/count width helpers used by the arbiter and dispatcher alike.
package vrp_disp_pkg;

   localparam int DISP_DEPTH     = 2;
   localparam int DISP_BIN_WIDTH = 4;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/vrp_disp_fifo.sv
// Single-channel DEPTH-entry FIFO used once per dispatcher output channel.
// Pushes into a full FIFO and pops from an empty one are ignored.
module vrp_disp_fifo
   import vrp_disp_pkg::*;
#(
   parameter type pld_t = logic,
   parameter int  DEPTH = DISP_DEPTH,
   localparam int PW    = ptr_width(DEPTH),
   localparam int CW    = cnt_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  pld_t          push_pld,
   input  logic          pop,
   output pld_t          pop_pld,
   output logic [CW-1:0] cnt,
   output logic          full,
   output logic          empty
);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;
   pld_t          mem [DEPTH];

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: ;
         endcase
      end
   end

   // NOTE: payload storage has no reset; validity is carried entirely by cnt.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_pld;
   end

   assign pop_pld = mem[rd_ptr];

endmodule

// File: rtl/vrp_disp_idx.sv
// Index-routed one-to-many dispatcher with a FIFO per output channel.
// Define VRP_DISP_BYPASS_EN to let a beat skip an empty, ready channel FIFO.
module vrp_disp_idx
   import vrp_disp_pkg::*;
#(
   parameter type pack_pld  = logic,
   parameter int  BIN_WIDTH = DISP_BIN_WIDTH,
   parameter int  DEPTH     = DISP_DEPTH,
   localparam int OH_WIDTH  = 1 << BIN_WIDTH,
   localparam int CW        = cnt_width(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_vld,
   output logic                         in_rdy,
   input  pack_pld                      in_pld,
   input  logic [BIN_WIDTH-1:0]         in_idx,
   output logic [OH_WIDTH-1:0]          v_out_vld,
   input  logic [OH_WIDTH-1:0]          v_out_rdy,
   output pack_pld [OH_WIDTH-1:0]       v_out_pld,
   output logic                         idle
);

   logic [OH_WIDTH-1:0] sel;
   logic [OH_WIDTH-1:0] push;
   logic [OH_WIDTH-1:0] pop;
   logic [OH_WIDTH-1:0] full;
   logic [OH_WIDTH-1:0] empty;
   logic [CW-1:0]       cnt      [OH_WIDTH];
   pack_pld             fifo_pld [OH_WIDTH];
   logic                acc;
   logic                byp;

   assign sel    = OH_WIDTH'(1) << in_idx;
   // Ready looks only at occupancy, never at v_out_rdy, to keep the paths apart.
   assign in_rdy = !full[in_idx];
   assign acc    = in_vld && in_rdy;

`ifdef VRP_DISP_BYPASS_EN
   assign byp = in_vld && empty[in_idx] && v_out_rdy[in_idx];
`else
   assign byp = 1'b0;
`endif

   // NOTE: every output of this block gets a default first so no latch can be inferred.
   always_comb begin
      push      = sel & {OH_WIDTH{acc && !byp}};
      v_out_vld = '0;
      v_out_pld = '0;
      idle      = 1'b1;
      for (int k = 0; k < OH_WIDTH; k++) begin
         v_out_vld[k] = !empty[k] || (byp && sel[k]);
         v_out_pld[k] = (byp && sel[k]) ? in_pld : fifo_pld[k];
         idle         = idle && (cnt[k] == '0);
      end
      pop = v_out_vld & v_out_rdy;
   end

   for (genvar k = 0; k < OH_WIDTH; k++) begin : g_ch
      vrp_disp_fifo #(
         .pld_t (pack_pld),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk      (clk),
         .rst_n    (rst_n),
         .push     (push[k]),
         .push_pld (in_pld),
         .pop      (pop[k]),
         .pop_pld  (fifo_pld[k]),
         .cnt      (cnt[k]),
         .full     (full[k]),
         .empty    (empty[k])
      );
   end

endmodule

// File: tb/tb_vrp_disp_idx.sv
// Self-checking bench for vrp_disp_idx: per-channel queue reference model,
// directed scenarios followed by randomized traffic.
module tb_vrp_disp_idx;

   localparam int BW    = 4;
   localparam int OH    = 1 << BW;
   localparam int DEPTH = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_vld;
   logic               in_rdy;
   logic [7:0]         in_pld;
   logic [BW-1:0]      in_idx;
   logic [OH-1:0]      v_out_vld;
   logic [OH-1:0]      v_out_rdy;
   logic [OH-1:0][7:0] v_out_pld;
   logic               idle;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] q [OH][$];
   logic       acc;

   vrp_disp_idx #(
      .pack_pld  (logic [7:0]),
      .BIN_WIDTH (BW),
      .DEPTH     (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_vld    (in_vld),
      .in_rdy    (in_rdy),
      .in_pld    (in_pld),
      .in_idx    (in_idx),
      .v_out_vld (v_out_vld),
      .v_out_rdy (v_out_rdy),
      .v_out_pld (v_out_pld),
      .idle      (idle)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: compare outputs against the queues at negedge, then advance the queues.
   task automatic cycle(input string tag);
      logic [OH-1:0] ev;
      logic          erdy;
      logic          ebyp;
      logic          eidle;
      @(negedge clk);
      erdy  = (q[in_idx].size() < DEPTH);
      ebyp  = 1'b0;
`ifdef VRP_DISP_BYPASS_EN
      ebyp  = in_vld && (q[in_idx].size() == 0) && v_out_rdy[in_idx];
`endif
      eidle = 1'b1;
      for (int k = 0; k < OH; k++) begin
         ev[k] = (q[k].size() != 0) || (ebyp && (int'(in_idx) == k));
         if (q[k].size() != 0) eidle = 1'b0;
      end
      check({tag, "_rdy"}, 32'(in_rdy), 32'(erdy));
      check({tag, "_idle"}, 32'(idle), 32'(eidle));
      check({tag, "_vld"}, 32'(v_out_vld), 32'(ev));
      for (int k = 0; k < OH; k++) begin
         if (ev[k]) begin
            if (q[k].size() != 0) check({tag, "_pld"}, 32'(v_out_pld[k]), 32'(q[k][0]));
            else                  check({tag, "_byp_pld"}, 32'(v_out_pld[k]), 32'(in_pld));
         end
      end
      @(posedge clk);
      for (int k = 0; k < OH; k++)
         if (ev[k] && v_out_rdy[k] && q[k].size() != 0) void'(q[k].pop_front());
      acc = in_vld && erdy;
      if (acc && !ebyp) q[in_idx].push_back(in_pld);
      #1;
   endtask

   task automatic send(input logic [BW-1:0] idx, input logic [7:0] pld, input int max_cyc);
      in_vld = 1'b1;
      in_idx = idx;
      in_pld = pld;
      for (int i = 0; i < max_cyc; i++) begin
         cycle("send");
         if (acc) break;
      end
      check("send_accept", 32'(acc), 32'd1);
      in_vld = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_vld    = 1'b0;
      in_pld    = '0;
      in_idx    = '0;
      v_out_rdy = '1;
      acc       = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset then idle
      check("rst_vld", 32'(v_out_vld), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_rdy", 32'(in_rdy), 32'd1);
      repeat (10) cycle("idle");

      // Single route to channel 3
      send(4'd3, 8'hA5, 1);
      cycle("route");
      cycle("route");

      // Channel 5 stalled and filled; channel 6 keeps flowing
      v_out_rdy = ~(OH'(1) << 5);
      send(4'd5, 8'h51, 2);
      send(4'd5, 8'h52, 2);
      for (int i = 0; i < 4; i++) send(4'd6, 8'h60 + 8'(i), 1);
      in_vld = 1'b1;
      in_idx = 4'd5;
      in_pld = 8'h53;
      cycle("bp");
      check("bp_hold", 32'(acc), 32'd0);
      cycle("bp");
      check("bp_hold", 32'(acc), 32'd0);
      v_out_rdy = '1;
      send(4'd5, 8'h53, 4);
      repeat (4) cycle("drain");

      // Full channel 2 popped in the cycle a beat targets it
      v_out_rdy = ~(OH'(1) << 2);
      send(4'd2, 8'h21, 2);
      send(4'd2, 8'h22, 2);
      v_out_rdy = '1;
      in_vld = 1'b1;
      in_idx = 4'd2;
      in_pld = 8'h23;
      cycle("pp");
      check("pp_block", 32'(acc), 32'd0);
      cycle("pp");
      check("pp_accept", 32'(acc), 32'd1);
      in_vld = 1'b0;
      repeat (4) cycle("pp_drain");

      // Randomized traffic, concentrated on a few channels to exercise full FIFOs
      for (int i = 0; i < 1500; i++) begin
         if (!in_vld || acc) begin
            in_vld = ($urandom_range(3) != 0);
            in_idx = ($urandom_range(1) != 0) ? BW'($urandom_range(3)) : BW'($urandom);
            in_pld = 8'($urandom);
         end
         v_out_rdy = OH'($urandom) | OH'($urandom);
         cycle("rnd");
      end
      in_vld    = 1'b0;
      v_out_rdy = '1;
      repeat (4) cycle("rnd_drain");

      // Asynchronous reset with two beats queued on channel 7
      v_out_rdy = ~(OH'(1) << 7);
      send(4'd7, 8'h71, 2);
      send(4'd7, 8'h72, 2);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_vld", 32'(v_out_vld), 32'd0);
      check("mrst_idle", 32'(idle), 32'd1);
      check("mrst_rdy", 32'(in_rdy), 32'd1);
      for (int k = 0; k < OH; k++) q[k].delete();
      acc = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      v_out_rdy = '1;
      repeat (5) cycle("post_rst");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
